// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed data memory for the Memory stage with
// WAIT_STATES extra busy cycles per access, stall output and misalign flag.
// Ports:
//   clk, reset (async, active-low)
//   MemReqM, MemWriteM, ALUOutM, WriteDataM : request from the Memory stage
//   ReadDataM  : registered load data, held until the next load
//   MemReadyM  : one-cycle completion pulse
//   MemStallM  : combinational freeze request to the hazard unit
//   MisalignM  : pulses with MemReadyM when ALUOutM[1:0] != 0
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReqM,
   input  logic        MemWriteM,
   input  logic [31:0] ALUOutM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        MemReadyM,
   output logic        MemStallM,
   output logic        MisalignM
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_n;

   logic [3:0]    cnt, cnt_n;
   logic [AW-1:0] idx_q;
   logic [31:0]   data_q;
   logic          write_q;
   logic          mis_q;
   logic          accept;
   logic          finish;

   logic [31:0] mem [DEPTH_WORDS];

   // Address bits above the word index wrap and are not stored.
   logic unused_addr;
   assign unused_addr = ^ALUOutM[31:AW+2];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      accept  = 1'b0;
      finish  = 1'b0;
      unique case (state)
         IDLE: begin
            if (MemReqM) begin
               accept  = 1'b1;
               cnt_n   = 4'(WAIT_STATES);
               state_n = BUSY;
            end
         end
         BUSY: begin
            if (cnt != 4'd0) begin
               cnt_n = cnt - 4'd1;
            end else begin
               finish  = 1'b1;
               state_n = RESP;
            end
         end
         RESP: begin
            // The same instruction is still presenting its request here,
            // so it is deliberately not re-accepted.
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign MemStallM = ((state == IDLE) && MemReqM) || (state == BUSY);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt       <= 4'd0;
         idx_q     <= '0;
         data_q    <= 32'd0;
         write_q   <= 1'b0;
         mis_q     <= 1'b0;
         ReadDataM <= 32'd0;
         MemReadyM <= 1'b0;
         MisalignM <= 1'b0;
      end else begin
         cnt       <= cnt_n;
         MemReadyM <= finish;
         MisalignM <= finish && mis_q;
         if (accept) begin
            idx_q   <= ALUOutM[AW+1:2];
            data_q  <= WriteDataM;
            write_q <= MemWriteM;
            mis_q   <= (ALUOutM[1:0] != 2'b00);
         end
         if (finish && !write_q) begin
            ReadDataM <= mis_q ? 32'd0 : mem[idx_q];
         end
      end
   end

   // Storage is not reset; an async reset forces IDLE so an aborted
   // store can never reach this write.
   always_ff @(posedge clk) begin
      if (finish && write_q && !mis_q) begin
         mem[idx_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (2 and 0 wait states) driven with
// directed and random accesses, checked cycle by cycle against a model.
module tb_dmem_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst [2];
   logic        req [2];
   logic        we  [2];
   logic [31:0] ad  [2];
   logic [31:0] wd  [2];
   logic [31:0] rd  [2];
   logic        rdy [2];
   logic        stl [2];
   logic        mis [2];

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] model   [2][64];
   logic [31:0] last_rd [2];

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut0 (
      .clk(clk), .reset(rst[0]),
      .MemReqM(req[0]), .MemWriteM(we[0]),
      .ALUOutM(ad[0]), .WriteDataM(wd[0]),
      .ReadDataM(rd[0]), .MemReadyM(rdy[0]),
      .MemStallM(stl[0]), .MisalignM(mis[0])
   );

   dmem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut1 (
      .clk(clk), .reset(rst[1]),
      .MemReqM(req[1]), .MemWriteM(we[1]),
      .ALUOutM(ad[1]), .WriteDataM(wd[1]),
      .ReadDataM(rd[1]), .MemReadyM(rdy[1]),
      .MemStallM(stl[1]), .MisalignM(mis[1])
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int ws(input int d);
      return (d == 0) ? 2 : 0;
   endfunction

   task automatic chk_idle(input int d);
      chk($sformatf("d%0d.idle_stall", d), 32'(stl[d]), 32'd0);
      chk($sformatf("d%0d.idle_ready", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("d%0d.idle_mis", d), 32'(mis[d]), 32'd0);
      chk($sformatf("d%0d.idle_rdata", d), rd[d], last_rd[d]);
   endtask

   task automatic idle(input int d);
      @(negedge clk);
      req[d] = 1'b0;
      #1;
      chk_idle(d);
   endtask

   task automatic access(input int d, input bit w,
                         input logic [31:0] a, input logic [31:0] v);
      int n;
      bit m;
      int idx;
      logic [31:0] exp_rd;
      n   = ws(d);
      m   = (a[1:0] != 2'b00);
      idx = int'(a[7:2]);
      if (w)      exp_rd = last_rd[d];
      else if (m) exp_rd = 32'd0;
      else        exp_rd = model[d][idx];
      for (int i = 0; i <= n + 2; i++) begin
         @(negedge clk);
         if (i == 0) begin
            req[d] = 1'b1;
            we[d]  = w;
            ad[d]  = a;
            wd[d]  = v;
         end
         #1;
         chk($sformatf("d%0d.stall c%0d", d, i), 32'(stl[d]),
             32'(i < n + 2));
         chk($sformatf("d%0d.ready c%0d", d, i), 32'(rdy[d]),
             32'(i == n + 2));
         chk($sformatf("d%0d.mis c%0d", d, i), 32'(mis[d]),
             32'((i == n + 2) && m));
         chk($sformatf("d%0d.rdata c%0d a=%h", d, i, a), rd[d],
             (i == n + 2) ? exp_rd : last_rd[d]);
      end
      last_rd[d] = exp_rd;
      if (w && !m) model[d][idx] = v;
      @(negedge clk);
      req[d] = 1'b0;
      we[d]  = 1'($urandom);
      ad[d]  = $urandom;
      wd[d]  = $urandom;
      #1;
      chk_idle(d);
   endtask

   // Reset is applied during busy cycle k (1..WAIT_STATES+1).
   task automatic abort_access(input int d, input bit w,
                               input logic [31:0] a, input logic [31:0] v,
                               input int k);
      for (int i = 0; i <= k; i++) begin
         @(negedge clk);
         if (i == 0) begin
            req[d] = 1'b1;
            we[d]  = w;
            ad[d]  = a;
            wd[d]  = v;
         end
         if (i == k) begin
            rst[d] = 1'b0;
            req[d] = 1'b0;
         end
         #1;
         if (i < k) begin
            chk($sformatf("d%0d.ab_stall c%0d", d, i), 32'(stl[d]), 32'd1);
         end
      end
      last_rd[d] = 32'd0;
      chk_idle(d);
      @(negedge clk);
      rst[d] = 1'b1;
      #1;
      chk_idle(d);
   endtask

   initial begin
      logic [31:0] a;
      int d;
      for (int i = 0; i < 2; i++) begin
         rst[i] = 1'b1;
         req[i] = 1'b0;
         we[i]  = 1'b0;
         ad[i]  = 32'd0;
         wd[i]  = 32'd0;
         last_rd[i] = 32'd0;
      end
      #1;
      rst[0] = 1'b0;
      rst[1] = 1'b0;
      #1;
      chk_idle(0);
      chk_idle(1);
      repeat (2) @(negedge clk);
      rst[0] = 1'b1;
      rst[1] = 1'b1;

      for (int i = 0; i < 10; i++) begin
         idle(0);
         chk_idle(1);
      end

      for (int dd = 0; dd < 2; dd++) begin
         for (int i = 0; i < 64; i++) begin
            access(dd, 1'b1, 32'(i * 4), $urandom);
         end
      end

      access(0, 1'b1, 32'h10, 32'hDEADBEEF);
      access(0, 1'b0, 32'h10, 32'h0);
      access(0, 1'b1, 32'h104, 32'h12345678);
      access(0, 1'b0, 32'h004, 32'h0);
      access(0, 1'b1, 32'h22, 32'hFFFFFFFF);
      access(0, 1'b0, 32'h20, 32'h0);
      access(0, 1'b0, 32'h21, 32'h0);
      access(1, 1'b0, 32'h0, 32'h0);
      access(1, 1'b1, 32'h8, 32'hCAFEF00D);
      access(1, 1'b0, 32'h8, 32'h0);
      abort_access(0, 1'b1, 32'h8, 32'hAAAA5555, 2);
      access(0, 1'b0, 32'h8, 32'h0);
      abort_access(1, 1'b1, 32'h8, 32'hAAAA5555, 1);
      access(1, 1'b0, 32'h8, 32'h0);

      for (int t = 0; t < 200; t++) begin
         d = int'($urandom_range(0, 1));
         a = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
         if ($urandom_range(0, 19) == 0) begin
            abort_access(d, 1'b1, a, $urandom,
                         int'($urandom_range(1, ws(d) + 1)));
         end else begin
            access(d, 1'($urandom), a, $urandom);
         end
         repeat ($urandom_range(0, 2)) idle(d);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end

endmodule
